// File: rtl/npc_pkg.sv
// Shared definitions for the fetch front end: IFU state encoding, reset PC
// default and the canonical NOP (addi x0, x0, 0).
package npc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } ifu_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
   localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

   // Sequential fetch advance; wraps naturally modulo 2^32.
   function automatic logic [31:0] pc_add4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/ifu_pc_gen.sv
// Next-PC generation for the IFU: sequential advance, redirect target and
// misaligned-target detection.
// Optional feature macro: IFU_MISALIGN_CHECK_EN. When defined, a redirect
// target with non-zero [1:0] is flagged as misaligned and passed through
// unmodified. When undefined, the low two bits are cleared and the flag is 0.
module ifu_pc_gen
   import npc_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic        advance_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] pc_next_o,
   output logic [31:0] redirect_tgt_o,
   output logic        redirect_misalign_o
);

`ifdef IFU_MISALIGN_CHECK_EN
   assign redirect_tgt_o      = redirect_pc_i;
   assign redirect_misalign_o = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
`else
   logic unused_lsb;
   assign unused_lsb          = ^redirect_pc_i[1:0];
   assign redirect_tgt_o      = {redirect_pc_i[31:2], 2'b00};
   assign redirect_misalign_o = 1'b0;
`endif

   // Redirect wins over the sequential advance; otherwise the PC holds.
   always_comb begin
      pc_next_o = pc_i;
      if (redirect_valid_i) begin
         pc_next_o = redirect_tgt_o;
      end else if (advance_i) begin
         pc_next_o = pc_add4(pc_i);
      end
   end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM (IDLE/REQ/WAIT/HOLD)
// with a registered output stage towards decode.
// Optional feature macro: IFU_MISALIGN_CHECK_EN (misaligned redirect targets
// are reported through out_misalign instead of being fetched).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Once raised, valid and its payload stay stable until that edge,
// except that a redirect may retarget a not-yet-accepted fetch request.
// imem_rsp_valid is a single-cycle pulse with no ready.
module ifu
   import npc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic        out_fault,
   output logic        out_misalign,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   ifu_state_e  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        kill_q, kill_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_inst_q, out_inst_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic        out_fault_q, out_fault_d;
   logic        out_misalign_q, out_misalign_d;

   logic        req_hs;
   logic        advance;
   logic [31:0] pc_next;
   logic [31:0] redirect_tgt;
   logic        redirect_misalign;

   // kill_q marks an accepted fetch whose response must be discarded; no new
   // request is issued until that stale response has come back.
   assign imem_req_valid = (state_q == REQ) && !kill_q;
   assign imem_req_addr  = pc_q;
   assign req_hs         = imem_req_valid && imem_req_ready;
   assign advance        = (state_q == HOLD) && out_ready;

   assign out_valid    = out_valid_q;
   assign out_inst     = out_inst_q;
   assign out_pc       = out_pc_q;
   assign out_fault    = out_fault_q;
   assign out_misalign = out_misalign_q;

   ifu_pc_gen u_pc_gen (
      .pc_i                (pc_q),
      .advance_i           (advance),
      .redirect_valid_i    (redirect_valid),
      .redirect_pc_i       (redirect_pc),
      .pc_next_o           (pc_next),
      .redirect_tgt_o      (redirect_tgt),
      .redirect_misalign_o (redirect_misalign)
   );

   // Next-state, PC, kill and output-register logic.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_next;
      kill_d         = kill_q && !imem_rsp_valid;
      out_valid_d    = out_valid_q;
      out_inst_d     = out_inst_q;
      out_pc_d       = out_pc_q;
      out_fault_d    = out_fault_q;
      out_misalign_d = out_misalign_q;

      case (state_q)
         IDLE: begin
            state_d = REQ;
         end

         REQ: begin
            if (redirect_valid) begin
               // An accepted request is now stale and must be flushed.
               if (req_hs) begin
                  kill_d = 1'b1;
               end
               if (redirect_misalign) begin
                  state_d = HOLD;
               end else if (req_hs) begin
                  state_d = WAIT;
               end
            end else if (req_hs) begin
               state_d = WAIT;
            end
         end

         WAIT: begin
            if (imem_rsp_valid) begin
               if (redirect_valid && redirect_misalign) begin
                  state_d = HOLD;
               end else if (redirect_valid || kill_q) begin
                  state_d = REQ;
               end else begin
                  state_d        = HOLD;
                  out_valid_d    = 1'b1;
                  out_inst_d     = imem_rsp_data;
                  out_pc_d       = pc_q;
                  out_fault_d    = imem_rsp_err;
                  out_misalign_d = 1'b0;
               end
            end else if (redirect_valid) begin
               kill_d = 1'b1;
               if (redirect_misalign) begin
                  state_d = HOLD;
               end
            end
         end

         HOLD: begin
            if (redirect_valid || out_ready) begin
               state_d        = REQ;
               out_valid_d    = 1'b0;
               out_inst_d     = NOP_INST;
               out_fault_d    = 1'b0;
               out_misalign_d = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // A misaligned redirect is presented to decode directly, no fetch.
      if (state_q != IDLE && redirect_valid && redirect_misalign) begin
         state_d        = HOLD;
         out_valid_d    = 1'b1;
         out_inst_d     = NOP_INST;
         out_pc_d       = redirect_tgt;
         out_fault_d    = 1'b0;
         out_misalign_d = 1'b1;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         pc_q           <= RESET_PC;
         kill_q         <= 1'b0;
         out_valid_q    <= 1'b0;
         out_inst_q     <= NOP_INST;
         out_pc_q       <= RESET_PC;
         out_fault_q    <= 1'b0;
         out_misalign_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         kill_q         <= kill_d;
         out_valid_q    <= out_valid_d;
         out_inst_q     <= out_inst_d;
         out_pc_q       <= out_pc_d;
         out_fault_q    <= out_fault_d;
         out_misalign_q <= out_misalign_d;
      end
   end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, value driven on out_inst when not valid.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 imem_req_valid  out  1  fetch request valid.
REQ-006 imem_req_ready  in  1  memory accepts request.
REQ-007 imem_req_addr  out  32  fetch address.
REQ-008 imem_rsp_valid  in  1  response valid, one-cycle pulse, never before the request is accepted.
REQ-009 imem_rsp_data  in  32  fetched instruction word.
REQ-010 imem_rsp_err  in  1  access fault, qualified by imem_rsp_valid.
REQ-011 out_valid  out  1  instruction available to decode.
REQ-012 out_ready  in  1  decode consumes instruction.
REQ-013 out_inst  out  32  instruction word.
REQ-014 out_pc  out  32  PC of out_inst.
REQ-015 out_fault  out  1  access fault flag for out_inst.
REQ-016 out_misalign  out  1  misaligned-target flag, see Configuration.
REQ-017 redirect_valid  in  1  PC redirect from branch, jal, jalr, trap or mret.
REQ-018 redirect_pc  in  32  redirect target.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT and HOLD, with at most one outstanding fetch.
REQ-020 IDLE SHALL go to REQ unconditionally, entered only from reset.
REQ-021 In REQ, imem_req_valid=1 and imem_req_addr=pc, held stable until imem_req_ready; handshake moves the FSM to WAIT.
REQ-022 In WAIT, imem_rsp_valid SHALL latch data, err and pc into the output register and move the FSM to HOLD.
REQ-023 In HOLD, out_valid=1 with stable outputs; out_valid&out_ready SHALL set pc=pc+4 (mod 2^32) and move the FSM to REQ.
REQ-024 Latency: with ready=1 and response the cycle after accept, out_valid SHALL assert 2 cycles after the request handshake; peak throughput is 1 instruction per 3 cycles.
REQ-025 Redirect in REQ before the handshake SHALL replace pc with redirect_pc, which overrides the address-stability rule.
REQ-026 Redirect in REQ on the handshake cycle, or in WAIT, SHALL set kill, store redirect_pc, drop the pending response on arrival, and return to REQ with the new pc.
REQ-027 Redirect in the same cycle as imem_rsp_valid SHALL drop that response; the FSM goes to REQ and out_valid stays 0.
REQ-028 Redirect in HOLD SHALL deassert out_valid next cycle, set pc=redirect_pc and go to REQ; if out_ready was also 1, the handshake counts as delivered and redirect_pc wins over pc+4.
REQ-029 Back-to-back redirects while kill is set SHALL keep only the latest target.
REQ-030 Outputs SHALL hold NOP_INST, out_fault=0 and out_misalign=0 whenever out_valid=0.
REQ-031 A faulting response SHALL still be delivered with out_fault=1, and fetch SHALL continue at pc+4 unless redirected.

Reset
REQ-032 rst SHALL force state=IDLE, pc=RESET_PC, kill=0, imem_req_valid=0, out_valid=0, out_inst=NOP_INST, out_pc=RESET_PC and flags=0.
REQ-033 rst mid-fetch SHALL abandon the transaction; a response arriving after reset with no new request accepted SHALL be ignored.

Configuration
REQ-034 Macro IFU_MISALIGN_CHECK_EN: when defined, a redirect_pc with [1:0]!=0 SHALL issue no request; the FSM goes directly to HOLD with out_misalign=1, out_inst=NOP_INST and out_pc=redirect_pc.
REQ-035 When the macro is undefined, redirect_pc[1:0] SHALL be forced to 2'b00 and out_misalign tied to 0.

Structure
REQ-036 Shared package npc_pkg SHALL hold the FSM state enum, the RESET_PC default and the NOP_INST constant.
REQ-037 Sub-module ifu_pc_gen SHALL compute next pc (pc+4, redirect or kill target) and the misalign check; the FSM and output register stay in ifu.

Verification
REQ-038 Bench: release reset with ready=1 and a 1-cycle response -> req_addr 0x80000000 in cycle 1; out_valid with out_pc 0x80000000 in cycle 3; next req_addr 0x80000004.
REQ-039 Bench: out_ready=0 for 5 cycles in HOLD -> outputs stable, no new request, then advance to pc+4 on release.
REQ-040 Bench: redirect 0x80000100 in WAIT -> stale response dropped, next req_addr 0x80000100, out_pc 0x80000100.
REQ-041 Bench: redirect and out_ready together in HOLD at pc 0x80000010 -> next request to redirect_pc, not 0x80000014.
REQ-042 Bench: rsp_err=1 on pc 0x80000008 -> out_fault=1, out_pc 0x80000008; with the macro, redirect 0x80000102 -> out_misalign=1 and no memory request.
REQ-043 Bench: assert rst in WAIT, late response arrives -> ignored; fetch restarts at RESET_PC.
